// File: rtl/ibex_rf_switch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rf_switch_ctrl_pkg
// Brief    : Shared types, constants and save-area address helper for the
//            register-file context-switch controller.
// Revision : 1.0 - initial release
// ============================================================================
package ibex_rf_switch_ctrl_pkg;

    typedef enum logic [2:0] {
        RF_SW_IDLE      = 3'd0,
        RF_SW_SAVE_REQ  = 3'd1,
        RF_SW_SAVE_WAIT = 3'd2,
        RF_SW_LOAD_REQ  = 3'd3,
        RF_SW_LOAD_WAIT = 3'd4,
        RF_SW_DONE      = 3'd5
    } rf_switch_state_e;

    localparam int unsigned c_RF_SAVE_AREA_BITS = 7;

    // Each register file owns a 2^area_bits byte window; register r lives at word r.
    function automatic logic [31:0] rf_save_addr(input logic [31:0]  rf_id,
                                                 input logic [4:0]   idx,
                                                 input int unsigned  area_bits);
        return (rf_id << area_bits) + {25'd0, idx, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_rf_switch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rf_switch_ctrl_if
// Brief    : Switch request, register-file port and data-bus bundle of the
//            context-switch controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ibex_rf_switch_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  switch_req_i;
    logic [31:0]           switch_id_i;
    logic                  switch_ack_o;
    logic                  switch_done_o;
    logic                  switch_err_o;
    logic [31:0]           active_rf_o;
    logic                  core_halt_o;
    logic [4:0]            rf_raddr_c_o;
    logic [DATA_WIDTH-1:0] rf_rdata_c_i;
    logic [4:0]            rf_waddr_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;
    logic                  rf_we_o;
    logic                  data_req_o;
    logic                  data_gnt_i;
    logic                  data_rvalid_i;
    logic                  data_we_o;
    logic [3:0]            data_be_o;
    logic [31:0]           data_addr_o;
    logic [31:0]           data_wdata_o;
    logic [31:0]           data_rdata_i;
    logic                  data_err_i;

    modport master (
        input  switch_req_i, switch_id_i, rf_rdata_c_i,
               data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        output switch_ack_o, switch_done_o, switch_err_o, active_rf_o, core_halt_o,
               rf_raddr_c_o, rf_waddr_o, rf_wdata_o, rf_we_o,
               data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o
    );

    modport slave (
        output switch_req_i, switch_id_i, rf_rdata_c_i,
               data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        input  switch_ack_o, switch_done_o, switch_err_o, active_rf_o, core_halt_o,
               rf_raddr_c_o, rf_waddr_o, rf_wdata_o, rf_we_o,
               data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/ibex_rf_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rf_switch_ctrl
// Brief    : Spills the active register file to memory and fills the target
//            file from its save area, one bus transaction at a time.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_rf_switch_ctrl
    import ibex_rf_switch_ctrl_pkg::*;
#(
    parameter logic [31:0] BOOT_REG_FILE  = 32'h0,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned SAVE_AREA_BITS = c_RF_SAVE_AREA_BITS,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input wire                    clk_i,
    input wire                    rst_i,
    ibex_rf_switch_ctrl_if.master bus
);

    localparam logic [2:0] c_IDLE      = RF_SW_IDLE;
    localparam logic [2:0] c_SAVE_REQ  = RF_SW_SAVE_REQ;
    localparam logic [2:0] c_SAVE_WAIT = RF_SW_SAVE_WAIT;
    localparam logic [2:0] c_LOAD_REQ  = RF_SW_LOAD_REQ;
    localparam logic [2:0] c_LOAD_WAIT = RF_SW_LOAD_WAIT;
    localparam logic [2:0] c_DONE      = RF_SW_DONE;

    localparam logic [4:0] c_FIRST_IDX = 5'd1;
    localparam logic [4:0] c_LAST_IDX  = 5'(NUM_REGS - 1);

    logic [2:0]  r_state,  w_state_nxt;
    logic [31:0] r_active, w_active_nxt;
    logic [31:0] r_target, w_target_nxt;
    logic [4:0]  r_idx,    w_idx_nxt;

    logic        w_ack, w_done, w_err, w_rf_we, w_req, w_we;
    logic [4:0]  w_raddr, w_waddr;
    logic [3:0]  w_be;
    logic [31:0] w_addr, w_wdata;
    logic [DATA_WIDTH-1:0] w_rf_wdata;
    logic [31:0] w_save_addr, w_load_addr;

    assign w_save_addr = rf_save_addr(r_active, r_idx, SAVE_AREA_BITS);
    assign w_load_addr = rf_save_addr(r_target, r_idx, SAVE_AREA_BITS);

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_target_nxt = r_target;
        w_idx_nxt    = r_idx;
        w_ack        = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_rf_we      = 1'b0;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_raddr      = '0;
        w_waddr      = '0;
        w_be         = '0;
        w_addr       = '0;
        w_wdata      = '0;
        w_rf_wdata   = '0;
        case (r_state)
            c_IDLE: begin
                w_ack = bus.switch_req_i;
                if (bus.switch_req_i) begin
                    w_target_nxt = bus.switch_id_i;
                    w_idx_nxt    = c_FIRST_IDX;
                    w_state_nxt  = (bus.switch_id_i == r_active) ? c_DONE : c_SAVE_REQ;
                end
            end
            c_SAVE_REQ: begin
                w_raddr = r_idx;
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_be    = 4'hF;
                w_addr  = w_save_addr;
                w_wdata = bus.rf_rdata_c_i;
                if (bus.data_gnt_i) w_state_nxt = c_SAVE_WAIT;
            end
            c_SAVE_WAIT: begin
                if (bus.data_rvalid_i) begin
                    if (bus.data_err_i) begin
                        w_err       = 1'b1;
                        w_state_nxt = c_IDLE;
                    end else if (r_idx == c_LAST_IDX) begin
                        w_idx_nxt   = c_FIRST_IDX;
                        w_state_nxt = c_LOAD_REQ;
                    end else begin
                        w_idx_nxt   = r_idx + 5'd1;
                        w_state_nxt = c_SAVE_REQ;
                    end
                end
            end
            c_LOAD_REQ: begin
                w_req  = 1'b1;
                w_be   = 4'hF;
                w_addr = w_load_addr;
                if (bus.data_gnt_i) w_state_nxt = c_LOAD_WAIT;
            end
            c_LOAD_WAIT: begin
                // Registers already restored stay restored if a later load faults.
                if (bus.data_rvalid_i) begin
                    if (bus.data_err_i) begin
                        w_err       = 1'b1;
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_rf_we    = 1'b1;
                        w_waddr    = r_idx;
                        w_rf_wdata = bus.data_rdata_i;
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt = c_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + 5'd1;
                            w_state_nxt = c_LOAD_REQ;
                        end
                    end
                end
            end
            c_DONE: begin
                w_done       = 1'b1;
                w_active_nxt = r_target;
                w_state_nxt  = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_IDLE;
            r_active <= BOOT_REG_FILE;
            r_target <= '0;
            r_idx    <= c_FIRST_IDX;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_target <= w_target_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

    assign bus.switch_ack_o  = w_ack;
    assign bus.switch_done_o = w_done;
    assign bus.switch_err_o  = w_err;
    assign bus.active_rf_o   = r_active;
    assign bus.core_halt_o   = (r_state != c_IDLE);
    assign bus.rf_raddr_c_o  = w_raddr;
    assign bus.rf_waddr_o    = w_waddr;
    assign bus.rf_wdata_o    = w_rf_wdata;
    assign bus.rf_we_o       = w_rf_we;
    assign bus.data_req_o    = w_req;
    assign bus.data_we_o     = w_we;
    assign bus.data_be_o     = w_be;
    assign bus.data_addr_o   = w_addr;
    assign bus.data_wdata_o  = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_rf_switch_ctrl
// Brief    : Self-checking bench: memory/register-file responder plus a
//            save-area reference model of complete context switches.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_rf_switch_ctrl;
    import ibex_rf_switch_ctrl_pkg::*;

    localparam int          NR   = 32;
    localparam int          SAB  = 7;
    localparam logic [31:0] BOOT = 32'h0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ibex_rf_switch_ctrl_if #(.DATA_WIDTH(32)) bus ();

    ibex_rf_switch_ctrl #(
        .BOOT_REG_FILE (BOOT),
        .NUM_REGS      (NR),
        .SAVE_AREA_BITS(SAB),
        .DATA_WIDTH    (32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] rf_model [NR];
    assign bus.rf_rdata_c_i = rf_model[bus.rf_raddr_c_o];

    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory responder state
    int          gnt_delay = 0, rv_lat = 1, err_at = 0, resp_cnt = 0;
    int          stall = 0, stall_viol = 0, be_viol = 0, pend_cnt = 0;
    logic [31:0] pend_data = '0;
    logic        pend_err = 1'b0, prev_stalled = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];

    always @(negedge clk) begin
        bus.data_rvalid_i = 1'b0;
        bus.data_err_i    = 1'b0;
        bus.data_rdata_i  = '0;
        bus.data_gnt_i    = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.data_rvalid_i = 1'b1;
                bus.data_rdata_i  = pend_data;
                bus.data_err_i    = pend_err;
            end
        end
        if (bus.data_req_o === 1'b1) begin
            if (bus.data_be_o !== 4'hF) be_viol++;
            if (prev_stalled && (bus.data_addr_o !== prev_addr ||
                                 bus.data_wdata_o !== prev_wdata ||
                                 bus.data_we_o !== prev_we)) stall_viol++;
            if (stall >= gnt_delay) begin
                bus.data_gnt_i = 1'b1;
                stall        = 0;
                prev_stalled = 1'b0;
                resp_cnt++;
                pend_err = (resp_cnt == err_at);
                pend_cnt = rv_lat;
                if (bus.data_we_o) begin
                    wr_addr_q.push_back(bus.data_addr_o);
                    wr_data_q.push_back(bus.data_wdata_o);
                    if (!pend_err) mem[bus.data_addr_o] = bus.data_wdata_o;
                    pend_data = '0;
                end else begin
                    rd_addr_q.push_back(bus.data_addr_o);
                    pend_data = mem_rd(bus.data_addr_o);
                end
            end else begin
                stall++;
                prev_stalled = 1'b1;
                prev_addr    = bus.data_addr_o;
                prev_wdata   = bus.data_wdata_o;
                prev_we      = bus.data_we_o;
            end
        end else begin
            stall        = 0;
            prev_stalled = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: land in the quiet part of the low phase and commit any register-file write.
    task automatic tick();
        @(negedge clk);
        #2;
        if (bus.rf_we_o === 1'b1) rf_model[bus.rf_waddr_o] = bus.rf_wdata_o;
    endtask

    logic [31:0] exp_active;
    logic [31:0] snap_active;
    logic [31:0] snap_rf [NR];
    logic [31:0] snap_tgt [NR];
    int sw_lat, sw_halt, sw_req, sw_acks;
    bit sw_err;

    task automatic do_switch(input logic [31:0] id, input bit keep, input logic [31:0] next_id);
        bit ended;
        tick();
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        resp_cnt = 0;
        stall_viol = 0;
        snap_active = exp_active;
        for (int r = 0; r < NR; r++) begin
            snap_rf[r]  = rf_model[r];
            snap_tgt[r] = mem_rd((id << SAB) + 32'(4 * r));
        end
        bus.switch_req_i = 1'b1;
        bus.switch_id_i  = id;
        #1;
        chk1("ack_in_idle", bus.switch_ack_o, 1'b1);
        chk("active_before_switch", bus.active_rf_o, exp_active);
        sw_lat = 0; sw_halt = 0; sw_req = 0; sw_acks = 0; sw_err = 0; ended = 0;
        for (int n = 1; n <= 5000; n++) begin
            tick();
            if (bus.core_halt_o === 1'b1) sw_halt++;
            if (bus.data_req_o === 1'b1) sw_req++;
            if (bus.switch_ack_o !== 1'b0) sw_acks++;
            if (n == 1) begin
                if (keep) bus.switch_id_i = next_id;
                else      bus.switch_req_i = 1'b0;
            end
            if (bus.switch_err_o === 1'b1) begin
                sw_err = 1; sw_lat = n; ended = 1;
                break;
            end
            if (bus.switch_done_o === 1'b1) begin
                sw_lat = n; ended = 1;
                break;
            end
        end
        chk1("switch_ended", ended, 1'b1);
    endtask

    // Expected outcome of a completed switch from the save-area layout alone.
    task automatic ref_check(input logic [31:0] tgt);
        chk("n_save_writes", 32'(wr_addr_q.size()), 32'(NR - 1));
        chk("n_load_reads", 32'(rd_addr_q.size()), 32'(NR - 1));
        for (int r = 1; r < NR; r++) begin
            logic [31:0] sa, la;
            sa = (snap_active << SAB) + 32'(4 * r);
            la = (tgt << SAB) + 32'(4 * r);
            if (wr_addr_q.size() == NR - 1) begin
                chk($sformatf("save_addr[%0d]", r), wr_addr_q[r-1], sa);
                chk($sformatf("save_data[%0d]", r), wr_data_q[r-1], snap_rf[r]);
            end
            if (rd_addr_q.size() == NR - 1)
                chk($sformatf("load_addr[%0d]", r), rd_addr_q[r-1], la);
            chk($sformatf("rf_restored[%0d]", r), rf_model[r], snap_tgt[r]);
            chk($sformatf("mem_saved[%0d]", r), mem_rd(sa), snap_rf[r]);
        end
    endtask

    function automatic logic [31:0] pick_id(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] v;
        v = 32'($urandom_range(1, 255));
        for (int k = 0; k < 64 && (v == a || v == b); k++) v = 32'($urandom_range(1, 255));
        return v;
    endfunction

    task automatic randomize_rf();
        for (int r = 1; r < NR; r++) rf_model[r] = $urandom;
    endtask

    function automatic int exp_latency(input int gd);
        return 4 * (NR - 1) + 1 + gd * 2 * (NR - 1);
    endfunction

    initial begin
        logic [31:0] tgt, id2;
        int          we_seen, halt_seen;
        bit          found;
        rst = 1'b1;
        bus.switch_req_i  = 1'b0;
        bus.switch_id_i   = '0;
        bus.data_gnt_i    = 1'b0;
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i  = '0;
        bus.data_err_i    = 1'b0;
        for (int r = 0; r < NR; r++) rf_model[r] = 32'(r) * 32'h1111;
        exp_active = BOOT;

        tick(); tick();
        chk1("rst_halt", bus.core_halt_o, 1'b0);
        chk("rst_active", bus.active_rf_o, BOOT);
        chk1("rst_done", bus.switch_done_o, 1'b0);
        chk1("rst_err", bus.switch_err_o, 1'b0);
        chk1("rst_ack", bus.switch_ack_o, 1'b0);
        chk1("rst_data_req", bus.data_req_o, 1'b0);
        chk1("rst_rf_we", bus.rf_we_o, 1'b0);
        chk("rst_data_addr", bus.data_addr_o, 32'h0);
        rst = 1'b0;

        // Zero-wait switch 0 -> 1 with the x_r = r*0x1111 pattern
        gnt_delay = 0;
        do_switch(32'd1, 1'b0, 32'd0);
        chk1("t1_err", sw_err, 1'b0);
        chk("t1_latency", 32'(sw_lat), 32'(exp_latency(0)));
        chk("t1_halt_cycles", 32'(sw_halt), 32'(exp_latency(0)));
        ref_check(32'd1);
        exp_active = 32'd1;
        tick();
        chk("t1_active_after", bus.active_rf_o, exp_active);
        chk1("t1_halt_released", bus.core_halt_o, 1'b0);

        // Same-id switch: no bus traffic, one halted cycle
        do_switch(exp_active, 1'b0, 32'd0);
        chk("t2_latency", 32'(sw_lat), 32'd1);
        chk("t2_bus_reqs", 32'(sw_req), 32'd0);
        chk("t2_halt_cycles", 32'(sw_halt), 32'd1);
        chk("t2_busy_acks", 32'(sw_acks), 32'd0);
        tick();
        chk("t2_active", bus.active_rf_o, exp_active);

        // Every grant delayed by three cycles
        gnt_delay = 3;
        randomize_rf();
        tgt = pick_id(exp_active, exp_active);
        do_switch(tgt, 1'b0, 32'd0);
        chk("t3_latency", 32'(sw_lat), 32'(exp_latency(3)));
        chk("t3_stall_stability", 32'(stall_viol), 32'd0);
        ref_check(tgt);
        exp_active = tgt;
        gnt_delay = 0;

        // Bus error on the fifth save response
        err_at = 5;
        randomize_rf();
        tgt = pick_id(exp_active, exp_active);
        do_switch(tgt, 1'b0, 32'd0);
        chk1("t4_err_pulse", sw_err, 1'b1);
        chk("t4_err_cycle", 32'(sw_lat), 32'd10);
        chk("t4_bus_writes", 32'(wr_addr_q.size()), 32'd5);
        chk("t4_bus_reads", 32'(rd_addr_q.size()), 32'd0);
        tick();
        chk("t4_active_kept", bus.active_rf_o, exp_active);
        chk1("t4_idle_again", bus.core_halt_o, 1'b0);
        chk1("t4_err_one_cycle", bus.switch_err_o, 1'b0);
        err_at = 0;

        // Request held through a whole switch, then a second one with a new id
        randomize_rf();
        tgt = pick_id(exp_active, exp_active);
        id2 = pick_id(exp_active, tgt);
        do_switch(tgt, 1'b1, id2);
        chk("t5_busy_acks", 32'(sw_acks), 32'd0);
        chk("t5_latency", 32'(sw_lat), 32'(exp_latency(0)));
        ref_check(tgt);
        exp_active = tgt;
        do_switch(id2, 1'b0, 32'd0);
        chk("t5b_latency", 32'(sw_lat), 32'(exp_latency(0)));
        ref_check(id2);
        exp_active = id2;

        // Randomised grant stalls and ids
        for (int it = 0; it < 3; it++) begin
            gnt_delay = $urandom_range(0, 2);
            randomize_rf();
            tgt = pick_id(exp_active, exp_active);
            do_switch(tgt, 1'b0, 32'd0);
            chk("rand_latency", 32'(sw_lat), 32'(exp_latency(gnt_delay)));
            ref_check(tgt);
            exp_active = tgt;
        end
        gnt_delay = 0;

        // Reset while a load response is outstanding; the late response must be ignored
        rv_lat = 3;
        tgt = pick_id(exp_active, BOOT);
        tick();
        rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        resp_cnt = 0;
        bus.switch_req_i = 1'b1;
        bus.switch_id_i  = tgt;
        tick();
        bus.switch_req_i = 1'b0;
        found = 0;
        for (int n = 0; n < 2000; n++) begin
            tick();
            if (rd_addr_q.size() == 4 && bus.data_req_o === 1'b0) begin
                found = 1;
                break;
            end
        end
        chk1("t6_reached_load_wait", found, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_active = BOOT;
        chk1("t6_halt", bus.core_halt_o, 1'b0);
        chk("t6_active", bus.active_rf_o, BOOT);
        chk1("t6_data_req", bus.data_req_o, 1'b0);
        chk1("t6_rf_we", bus.rf_we_o, 1'b0);
        chk1("t6_done", bus.switch_done_o, 1'b0);
        chk1("t6_err", bus.switch_err_o, 1'b0);
        chk("t6_addr", bus.data_addr_o, 32'h0);
        we_seen = 0; halt_seen = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (bus.rf_we_o !== 1'b0) we_seen++;
            if (bus.core_halt_o !== 1'b0) halt_seen++;
        end
        chk("t6_late_rvalid_writes", 32'(we_seen), 32'd0);
        chk("t6_late_rvalid_halt", 32'(halt_seen), 32'd0);
        rv_lat = 1;

        // Normal operation resumes after the abandoned switch
        randomize_rf();
        tgt = pick_id(exp_active, exp_active);
        do_switch(tgt, 1'b0, 32'd0);
        chk("t7_latency", 32'(sw_lat), 32'(exp_latency(0)));
        ref_check(tgt);
        exp_active = tgt;
        tick();
        chk("t7_active", bus.active_rf_o, exp_active);
        chk("byte_enables", 32'(be_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
